// File: rtl/rca_seq_ctrl_pkg.sv
// rtl/rca_seq_ctrl_pkg.sv - shared constants, FSM encoding and index-width helper for rca_seq_ctrl
package rca_seq_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// rtl/ripple_carry_adder.sv - combinational SLICE_W-bit ripple carry adder
module ripple_carry_adder
    import rca_seq_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               carry
);

    logic w_c;

    always_comb begin
        w_c = cin;
        sum = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ w_c;
            w_c    = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        carry = w_c;
    end

endmodule

// File: rtl/rca_seq_ctrl.sv
// rtl/rca_seq_ctrl.sv - wide add sequencer over one 4-bit ripple adder, one slice per clock
// Optional subtract mode enabled by macro RCA_SUB_EN.
module rca_seq_ctrl
    import rca_seq_ctrl_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              cin,
`ifdef RCA_SUB_EN
    input  logic              op_sub,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              busy
);

    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int IDX_W  = idx_width(NSLICE);

    generate
        if ((DATA_W % SLICE_W) != 0 || DATA_W < SLICE_W) begin : g_bad_width
            $error("rca_seq_ctrl: DATA_W must be a positive multiple of SLICE_W");
        end
    endgenerate

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic                r_carry;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_sum;
    logic                r_cout;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;
`ifdef RCA_SUB_EN
    logic                r_sub;
`endif

    logic [31:0]         w_base;
    logic [SLICE_W-1:0]  w_a_slice;
    logic [SLICE_W-1:0]  w_b_slice;
    logic [SLICE_W-1:0]  w_slice_sum;
    logic                w_slice_carry;

    assign w_base    = 32'(r_idx) * 32'(SLICE_W);
    assign w_a_slice = r_a[w_base +: SLICE_W];
`ifdef RCA_SUB_EN
    // Two's-complement subtract: invert B here, carry reg was preloaded with 1.
    assign w_b_slice = r_sub ? ~r_b[w_base +: SLICE_W] : r_b[w_base +: SLICE_W];
`else
    assign w_b_slice = r_b[w_base +: SLICE_W];
`endif

    ripple_carry_adder u_adder (
        .a     (w_a_slice),
        .b     (w_b_slice),
        .cin   (r_carry),
        .sum   (w_slice_sum),
        .carry (w_slice_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef RCA_SUB_EN
            r_sub       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a        <= op_a;
                        r_b        <= op_b;
`ifdef RCA_SUB_EN
                        r_sub      <= op_sub;
                        r_carry    <= op_sub ? 1'b1 : cin;
`else
                        r_carry    <= cin;
`endif
                        r_idx      <= '0;
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_sum[w_base +: SLICE_W] <= w_slice_sum;
                    r_carry                  <= w_slice_carry;
                    if (r_idx == IDX_W'(NSLICE - 1)) begin
                        r_idx       <= '0;
                        r_cout      <= w_slice_carry;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign busy      = r_busy;

endmodule
